// File: rtl/pool_window_gen_pkg.sv
// Shared defaults and helpers for the pool_window_gen slice.
// Optional feature macro: POOL_WINDOW_POS_EN (window position outputs).
package pool_window_gen_pkg;

    localparam int IF_BW_DEF        = 32;
    localparam int CH_DEF           = 1;
    localparam int POOL_K_DEF       = 2;
    localparam int STRIDE_DEF       = 2;
    localparam int POOL_IN_SIZE_DEF = 8;

    // Bit offset of window element (wy, wx, c) in the flattened window bus.
    function automatic int win_idx(input int wy, input int wx, input int c,
                                   input int k, input int ch, input int bw);
        return ((wy * k + wx) * ch + c) * bw;
    endfunction

    // Last stride-aligned window anchor (bottom-right) along one axis.
    function automatic int last_pos(input int size, input int k, input int stride);
        return (k - 1) + ((size - k) / stride) * stride;
    endfunction

    // Counter width that stays at least one bit for degenerate ranges.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_window_gen_if.sv
// Pixel-in / window-out handshake bundle for pool_window_gen.
// Optional feature macro: POOL_WINDOW_POS_EN adds o_win_x / o_win_y.
interface pool_window_gen_if #(
    parameter int IF_BW = 32,
    parameter int CH    = 1,
    parameter int K     = 2
`ifdef POOL_WINDOW_POS_EN
    ,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
`endif
);
    localparam int PW = CH * IF_BW;
    localparam int WW = K * K * PW;

    logic          i_in_valid;
    logic          i_in_ready;
    logic          i_in_sof;
    logic [PW-1:0] i_in_pixel;
    logic          o_window_valid;
    logic          i_out_ready;
    logic [WW-1:0] o_window;
    logic          o_window_last;
`ifdef POOL_WINDOW_POS_EN
    logic [$clog2(IMG_W)-1:0] o_win_x;
    logic [$clog2(IMG_H)-1:0] o_win_y;
`endif

    // Window generator side.
    modport slave (
        input  i_in_valid, i_in_sof, i_in_pixel, i_out_ready,
        output i_in_ready, o_window_valid, o_window, o_window_last
`ifdef POOL_WINDOW_POS_EN
        , output o_win_x, o_win_y
`endif
    );

    // Pixel source / window sink side.
    modport master (
        output i_in_valid, i_in_sof, i_in_pixel, i_out_ready,
        input  i_in_ready, o_window_valid, o_window, o_window_last
`ifdef POOL_WINDOW_POS_EN
        , input o_win_x, o_win_y
`endif
    );

endinterface

// File: rtl/pool_line_mem.sv
// One line of pixel storage: single write port and asynchronous read port
// sharing the column address, so a column can be read and replaced in the
// same accept cycle. Contents are deliberately not reset.
module pool_line_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] line_q [DEPTH];

    assign rd_data = line_q[addr];

    // Replace the stored column value on write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_q[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/pool_window_gen.sv
// K x K sliding-window generator over a raster multi-channel pixel stream.
// K-1 line memories plus a column shift register form the window; one
// registered output slot with ready/valid, sof resync and last-window flag.
// Optional feature macro: POOL_WINDOW_POS_EN (top-left window coordinate).
module pool_window_gen
    import pool_window_gen_pkg::*;
#(
    parameter int IF_BW  = IF_BW_DEF,
    parameter int CH     = CH_DEF,
    parameter int IMG_W  = POOL_IN_SIZE_DEF,
    parameter int IMG_H  = POOL_IN_SIZE_DEF,
    parameter int K      = POOL_K_DEF,
    parameter int STRIDE = STRIDE_DEF
) (
    input logic              clk,
    input logic              reset,
    pool_window_gen_if.slave bus
);

    localparam int PW = CH * IF_BW;
    localparam int WW = K * K * PW;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int SW = cnt_w(STRIDE);

    localparam logic [XW-1:0] X_MAX   = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_FIRST = XW'(K - 1);
    localparam logic [YW-1:0] Y_FIRST = YW'(K - 1);
    localparam logic [XW-1:0] X_LAST  = XW'(last_pos(IMG_W, K, STRIDE));
    localparam logic [YW-1:0] Y_LAST  = YW'(last_pos(IMG_H, K, STRIDE));
    localparam logic [SW-1:0] S_MAX   = SW'(STRIDE - 1);

    logic [XW-1:0] x_q, x_d, x_cur;
    logic [YW-1:0] y_q, y_d, y_cur;
    logic [SW-1:0] sx_q, sx_d, sx_cur;
    logic [SW-1:0] sy_q, sy_d, sy_cur;

    logic in_ready, accept, win_hit, load;

    logic [K-2:0][PW-1:0]         rd_data;
    logic [K-1:0][PW-1:0]         col;
    logic [K-2:0][K-1:0][PW-1:0]  sh_q, sh_d;

    logic [WW-1:0] window_q, window_d;
    logic          window_valid_q, window_valid_d;
    logic          window_last_q, window_last_d;

    assign in_ready = !window_valid_q || bus.i_out_ready;
    assign accept   = bus.i_in_valid && in_ready;

    // Position of the pixel on the bus; sof forces it to the frame origin.
    always_comb begin
        x_cur  = x_q;
        y_cur  = y_q;
        sx_cur = sx_q;
        sy_cur = sy_q;
        if (bus.i_in_sof) begin
            x_cur  = '0;
            y_cur  = '0;
            sx_cur = '0;
            sy_cur = '0;
        end
    end

    // Raster counters and stride phases advance only on accept; a phase
    // sits at 0 until its axis reaches K-1, then cycles through STRIDE.
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        sx_d = sx_q;
        sy_d = sy_q;
        if (accept) begin
            y_d  = y_cur;
            sy_d = sy_cur;
            if (x_cur == X_MAX) begin
                x_d  = '0;
                sx_d = '0;
                if (y_cur == Y_MAX) begin
                    y_d  = '0;
                    sy_d = '0;
                end else begin
                    y_d  = y_cur + YW'(1);
                    sy_d = (y_cur < Y_FIRST || sy_cur == S_MAX) ? '0 : sy_cur + SW'(1);
                end
            end else begin
                x_d  = x_cur + XW'(1);
                sx_d = (x_cur < X_FIRST || sx_cur == S_MAX) ? '0 : sx_cur + SW'(1);
            end
        end
    end

    assign win_hit = (x_cur >= X_FIRST) && (y_cur >= Y_FIRST) &&
                     (sx_cur == '0) && (sy_cur == '0);
    assign load    = accept && win_hit;

    // Column x, oldest row at index 0, newest (incoming pixel) on top.
    assign col = {bus.i_in_pixel, rd_data};

    for (genvar r = 0; r < K - 1; r++) begin : g_line
        pool_line_mem #(
            .DEPTH (IMG_W),
            .WIDTH (PW),
            .AW    (XW)
        ) u_line (
            .clk     (clk),
            .wr_en   (accept),
            .addr    (x_cur),
            .wr_data (col[r+1]),
            .rd_data (rd_data[r])
        );
    end

    // Keep the K-1 previously accepted columns for the left of the window.
    always_comb begin
        sh_d = sh_q;
        if (accept) begin
            for (int i = 0; i < K - 2; i++) begin
                sh_d[i] = sh_q[i+1];
            end
            sh_d[K-2] = col;
        end
    end

    // Output slot: load on a window hit, clear on handshake, else hold.
    always_comb begin
        window_d       = window_q;
        window_valid_d = window_valid_q;
        window_last_d  = window_last_q;
        if (load) begin
            window_valid_d = 1'b1;
            window_last_d  = (x_cur == X_LAST) && (y_cur == Y_LAST);
            for (int wy = 0; wy < K; wy++) begin
                for (int wx = 0; wx < K - 1; wx++) begin
                    window_d[win_idx(wy, wx, 0, K, CH, IF_BW) +: PW] = sh_q[wx][wy];
                end
                window_d[win_idx(wy, K - 1, 0, K, CH, IF_BW) +: PW] = col[wy];
            end
        end else if (bus.i_out_ready) begin
            window_valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q            <= '0;
            y_q            <= '0;
            sx_q           <= '0;
            sy_q           <= '0;
            sh_q           <= '0;
            window_q       <= '0;
            window_valid_q <= 1'b0;
            window_last_q  <= 1'b0;
        end else begin
            x_q            <= x_d;
            y_q            <= y_d;
            sx_q           <= sx_d;
            sy_q           <= sy_d;
            sh_q           <= sh_d;
            window_q       <= window_d;
            window_valid_q <= window_valid_d;
            window_last_q  <= window_last_d;
        end
    end

    assign bus.i_in_ready     = in_ready;
    assign bus.o_window       = window_q;
    assign bus.o_window_valid = window_valid_q;
    assign bus.o_window_last  = window_last_q;

`ifdef POOL_WINDOW_POS_EN
    logic [XW-1:0] win_x_q, win_x_d;
    logic [YW-1:0] win_y_q, win_y_d;

    // Top-left coordinate captured alongside the window.
    always_comb begin
        win_x_d = win_x_q;
        win_y_d = win_y_q;
        if (load) begin
            win_x_d = x_cur - X_FIRST;
            win_y_d = y_cur - Y_FIRST;
        end
    end

    // Position registers, reset to the origin.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_x_q <= '0;
            win_y_q <= '0;
        end else begin
            win_x_q <= win_x_d;
            win_y_q <= win_y_d;
        end
    end

    assign bus.o_win_x = win_x_q;
    assign bus.o_win_y = win_y_q;
`endif

endmodule

// File: doc/pool_window_gen.md
Name: pool_window_gen

Overview:
- Parametrised K×K sliding-window generator for the CNN pooling and convolution stages.
- Accepts a raster-order multi-channel pixel stream and buffers K-1 previous lines plus the current line.
- Emits one registered K×K×CH window per stride position.
- Adds ready/valid backpressure, start-of-frame resync, non-square frames and a last-window flag, none of which the previous fixed pooling buffer supported.

Parameters:
- IF_BW, 32, bits per channel sample.
- CH, 1, channels per pixel. All channels are carried in lockstep.
- IMG_W, 8, frame width in pixels. Must be ≥ K.
- IMG_H, 8, frame height in lines. Must be ≥ K.
- K, 2, window side. Must be ≥ 2.
- STRIDE, 2, window step in x and y. Must be ≥ 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_in_valid  in  1  input pixel valid.
- i_in_ready  out  1  block can accept a pixel this cycle.
- i_in_sof  in  1  accepted pixel is (0,0) of a new frame.
- i_in_pixel  in  CH*IF_BW  pixel; channel c is at bits [c*IF_BW +: IF_BW].
- o_window_valid  out  1  window valid.
- i_out_ready  in  1  downstream accepts the window.
- o_window  out  K*K*CH*IF_BW  window; element (wy,wx,c) is at bits [((wy*K+wx)*CH+c)*IF_BW +: IF_BW]. wy=0 is the oldest line; wx=0 is the leftmost column.
- o_window_last  out  1  window is the last window of the frame.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: o_window_valid=0, o_window=0, o_window_last=0. x_cnt and y_cnt are 0. Line-memory contents are not reset.
- Accept rule: a pixel is accepted when i_in_valid && i_in_ready.
  - i_in_ready = !o_window_valid || i_out_ready.
  - This is a single output register; the input is not stalled while the output is empty.
- Counters advance only on accept.
  - x wraps at IMG_W-1 to 0 and increments y.
  - y wraps at IMG_H-1 to 0.
- i_in_sof resync: an accepted pixel with i_in_sof=1 is treated as (0,0) regardless of the counters, and the counters continue from (1,0).
- Line storage:
  - K-1 line memories, each IMG_W×CH*IF_BW.
  - On accept at column x, each line shifts up one row at that column and the newest row takes i_in_pixel.
  - A K-deep column shift register holds the K values of column x. Together these form the window.
- Window condition, evaluated on the accepted pixel at (x,y):
  - x ≥ K-1 and y ≥ K-1;
  - (x-(K-1)) % STRIDE == 0;
  - (y-(K-1)) % STRIDE == 0.
- Latency: if the window condition holds, o_window is loaded and o_window_valid is set on the next clock edge, i.e. 1 cycle after accept.
- The window contains the pixels at rows y-K+1..y and columns x-K+1..x, with the accepted pixel in the (K-1,K-1) slot.
- Hold under stall: o_window, o_window_valid and o_window_last hold while o_window_valid && !i_out_ready.
- Clear: o_window_valid clears on the output handshake unless a new window is loaded on the same edge. Simultaneous in/out handshakes must give back-to-back windows with no bubble.
- o_window_last = 1 when the window is the last one in the frame, i.e. its x and y are the last stride-aligned positions ≥ K-1.
- Window counts:
  - Windows per frame = ((IMG_W-K)/STRIDE+1) × ((IMG_H-K)/STRIDE+1), using integer division.
  - Trailing columns or rows not reachable by the stride produce no window.
- Reset mid-frame: the output is dropped and counters go to 0. The next frame must complete K-1 lines before any window is produced; stale line data is never emitted.
- Arithmetic: counters are $clog2(IMG_W) and $clog2(IMG_H) bits wide. STRIDE phase uses a per-axis counter, not a % operator in hardware.

Optional Feature:
- Macro: POOL_WINDOW_POS_EN.
- Defined: adds output ports o_win_x [$clog2(IMG_W)-1:0] and o_win_y [$clog2(IMG_H)-1:0].
  - They carry the top-left window coordinate (x-K+1, y-K+1).
  - They are registered with o_window, reset to 0, and held under stall.
- Undefined: the ports do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package/defines (extend stage3_defines_cnn_core.vh): IF_BW, POOL_K, STRIDE, POOL_IN_SIZE defaults, and a window-index macro ((wy*K+wx)*CH+c)*IF_BW.
- One sub-module: pool_line_mem, a single-port-write, single-port-read line RAM of IMG_W×(CH*IF_BW). It is instantiated K-1 times via generate.

Test Plan:
- IMG 8×8, K=2, STRIDE=2, CH=1, pixel=y*8+x, no stall → 16 windows.
  - First window = {0,1,8,9}; last window = {54,55,62,63} with o_window_last=1.
  - Each window appears 1 cycle after its accept.
- IMG 8×8, K=3, STRIDE=1 → 36 windows. First window = {0,1,2,8,9,10,16,17,18}.
- IMG 7×5, K=2, STRIDE=2 → 6 windows. Column 6 and row 4 produce none.
- K=2, STRIDE=2, i_out_ready=0 for 5 cycles on the first window:
  - the window holds stable;
  - i_in_ready=0;
  - no pixel is lost;
  - the total remains 16 windows with correct data.
- Assert reset after 20 pixels, then send a fresh frame → no window before pixel (1,1). Data equals the clean-run golden.
- i_in_sof asserted mid-frame at pixel 30, followed by a full frame → counters resync and the full 16-window golden is produced.
- With POOL_WINDOW_POS_EN: o_win_x/o_win_y sequence (0,0),(2,0)…(6,6).
